l1i_cache: RTL and testbench
============================

L1I_CACHE -- requirements
Module: l1i_cache

Interface
REQ-001 Params SHALL be: addressWidth 64 (address bits); cacheLineWith 512 (line bits); instructionWidth 32; offsetWidth 6; indexWidth 8 (256 lines); tagWidth = addressWidth-indexWidth-offsetWidth (50); PidSize 20; TidSize 16; instructionCounterWidth 64.
REQ-002 One clock and asynchronous active-low reset: clock_i in 1, rising-edge clock; cacheReset_i in 1, asynchronous, active-low.
REQ-003 fetchEnable_i in 1, fetch request; fetchStall_i in 1, freeze pipeline; fetchAddress_i in 64; Pid_i in 20; Tid_i in 16.
REQ-004 cacheUpdate_i in 1, miss-fill strobe; cacheUpdateAddress_i in 64; cacheUpdatePid_i in 20; cacheUpdateTid_i in 16; missedInstMajorId_i in 64, resume ID; cacheUpdateLine_i in 512.
REQ-005 naturalWriteEn_i in 1, non-miss line write; naturalWriteAddress_i in 64; naturalWriteLine_i in 512; naturalPid_i in 20; naturalTid_i in 16.
REQ-006 outputEnable_o out 1, bundle valid; outputBundle_o out 128; bundleAddress_o out 64; bundleLen_o out 2, instruction count minus 1; bundlePid_o out 20; bundleTid_o out 16; bundleStartMajId_o out 64, ID of first instruction.
REQ-007 cacheMiss_o out 1; missedAddress_o out 64; missedInstMajorId_o out 64; missedPid_o out 20; missedTid_o out 16.
REQ-008 All vectors SHALL be MSB-first [0:N-1]; address = {tag[0:49], index[50:57], offset[58:63]}.

Function
REQ-009 Direct-mapped, 256 entries; each holds valid, tag, PID, TID, 512-bit line.
REQ-010 Hit SHALL be: valid AND stored tag == address tag AND stored PID == Pid_i; TID is stored but not compared.
REQ-011 State machine SHALL have two states: RUN and MISS.
REQ-012 RUN, fetchEnable_i=1, fetchStall_i=0, hit: next edge sets outputEnable_o=1, bundleAddress_o=fetchAddress_i, bundlePid_o/bundleTid_o=Pid_i/Tid_i, bundleStartMajId_o=counter; counter += bundleLen_o+1. Latency is 1 cycle.
REQ-013 Bundle = up to 4 instructions from the 4-byte-aligned word at offset (low 2 offset bits ignored), truncated at line end; count = min(4, 16 - offset[58:61]).
REQ-014 First instruction SHALL occupy bundle bits 0:31 (line bits offset*8 onward); unused slots are 0.
REQ-015 RUN, fetchEnable_i=1, fetchStall_i=0, miss: next edge sets cacheMiss_o=1 and outputEnable_o=0. missedAddress_o, missedPid_o and missedTid_o latch the request; missedInstMajorId_o = counter. State goes to MISS.
REQ-016 An edge with no hit issued SHALL clear outputEnable_o; the bundle data outputs hold their last values.
REQ-017 fetchStall_i=1: all outputs, counter and state hold; writes still proceed.
REQ-018 MISS: fetches ignored; outputEnable_o=0; miss outputs hold.
REQ-019 cacheUpdate_i=1 in any state: write line, tag, PID, TID to the index of cacheUpdateAddress_i and set valid.
REQ-020 cacheUpdate_i=1 in MISS: load counter with missedInstMajorId_i, clear cacheMiss_o, return to RUN next edge.
REQ-021 naturalWriteEn_i=1: same write using the natural* inputs; no state change.
REQ-022 Simultaneous writes to the same index: cacheUpdate_i SHALL win.
REQ-023 Simultaneous writes to different indices: both SHALL complete.
REQ-024 A fetch in the same cycle as a write to its index SHALL see the old contents.
REQ-025 Counter SHALL wrap modulo 2^64.

Reset
REQ-026 cacheReset_i low SHALL immediately clear all valid bits, the counter, all outputs and cacheMiss_o, and enter RUN, including mid-MISS.
REQ-027 After reset every fetch SHALL miss until its line is written.

Verification
REQ-028 Reset, natural-write lines 0x000..0x240 (10 lines, PID/TID 0), fetch 0x000 step 0x10 ×40 -> each next edge outputEnable_o=1, cacheMiss_o=0, bundleLen_o=3, bundleStartMajId_o 0,4,8,…
REQ-029 Line pattern AAAAAAAA_BBBBBBBB_…, fetch 0x000 -> bundle AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD; fetch 0x010 -> EEEEEEEE_FFFFFFFF_AAAAAAAA_BBBBBBBB.
REQ-030 Fetch 0x280 (unwritten) -> cacheMiss_o=1, missedAddress_o=0x280, outputEnable_o=0; further fetches ignored.
REQ-031 In MISS, cacheUpdate_i with address 0x280 and missedInstMajorId_i=0xA0 -> cacheMiss_o=0; refetch 0x280 hits with bundleStartMajId_o=0xA0.
REQ-032 Fetch 0x038 -> bundleLen_o=1, instructions 2 and 3 of the bundle zero.
REQ-033 Fetch with Pid_i=1 on a line written with PID 0 -> miss.
REQ-034 cacheReset_i low mid-MISS -> cacheMiss_o=0; refetch 0x000 misses.

Source files
------------

// File: rtl/l1i_cache.sv
// Direct-mapped 256-line L1 instruction cache delivering up to four instructions per fetch.
// A miss parks the FSM in MISS until the refill strobe restores the instruction counter.
module l1i_cache #(
    parameter int unsigned addressWidth            = 64,
    parameter int unsigned cacheLineWith           = 512,
    parameter int unsigned instructionWidth        = 32,
    parameter int unsigned offsetWidth             = 6,
    parameter int unsigned indexWidth              = 8,
    parameter int unsigned tagWidth                = addressWidth - indexWidth - offsetWidth,
    parameter int unsigned PidSize                 = 20,
    parameter int unsigned TidSize                 = 16,
    parameter int unsigned instructionCounterWidth = 64
) (
    input  logic                                 clock_i,
    input  logic                                 cacheReset_i,
    input  logic                                 fetchEnable_i,
    input  logic                                 fetchStall_i,
    input  logic [0:addressWidth-1]              fetchAddress_i,
    input  logic [0:PidSize-1]                   Pid_i,
    input  logic [0:TidSize-1]                   Tid_i,
    input  logic                                 cacheUpdate_i,
    input  logic [0:addressWidth-1]              cacheUpdateAddress_i,
    input  logic [0:PidSize-1]                   cacheUpdatePid_i,
    input  logic [0:TidSize-1]                   cacheUpdateTid_i,
    input  logic [0:instructionCounterWidth-1]   missedInstMajorId_i,
    input  logic [0:cacheLineWith-1]             cacheUpdateLine_i,
    input  logic                                 naturalWriteEn_i,
    input  logic [0:addressWidth-1]              naturalWriteAddress_i,
    input  logic [0:cacheLineWith-1]             naturalWriteLine_i,
    input  logic [0:PidSize-1]                   naturalPid_i,
    input  logic [0:TidSize-1]                   naturalTid_i,
    output logic                                 outputEnable_o,
    output logic [0:4*instructionWidth-1]        outputBundle_o,
    output logic [0:addressWidth-1]              bundleAddress_o,
    output logic [0:1]                           bundleLen_o,
    output logic [0:PidSize-1]                   bundlePid_o,
    output logic [0:TidSize-1]                   bundleTid_o,
    output logic [0:instructionCounterWidth-1]   bundleStartMajId_o,
    output logic                                 cacheMiss_o,
    output logic [0:addressWidth-1]              missedAddress_o,
    output logic [0:instructionCounterWidth-1]   missedInstMajorId_o,
    output logic [0:PidSize-1]                   missedPid_o,
    output logic [0:TidSize-1]                   missedTid_o
);

    localparam int unsigned LINES  = 1 << indexWidth;
    localparam int unsigned WORDS  = cacheLineWith / instructionWidth;
    localparam int unsigned WSEL   = offsetWidth - 2;
    localparam int unsigned BUNDLE = 4 * instructionWidth;

    typedef enum logic {RUN, MISS} state_t;

    logic [0:LINES-1]         valid_q;
    logic [0:tagWidth-1]      tag_q  [LINES];
    logic [0:PidSize-1]       pid_q  [LINES];
    logic [0:TidSize-1]       tid_q  [LINES];
    logic [0:cacheLineWith-1] line_q [LINES];

    state_t                               state_q;
    logic [0:instructionCounterWidth-1]   cnt_q;
    logic                                 oe_q;
    logic [0:BUNDLE-1]                    bundle_q;
    logic [0:addressWidth-1]              baddr_q;
    logic [0:1]                           blen_q;
    logic [0:PidSize-1]                   bpid_q;
    logic [0:TidSize-1]                   btid_q;
    logic [0:instructionCounterWidth-1]   bstart_q;
    logic                                 miss_q;
    logic [0:addressWidth-1]              maddr_q;
    logic [0:instructionCounterWidth-1]   mid_q;
    logic [0:PidSize-1]                   mpid_q;
    logic [0:TidSize-1]                   mtid_q;

    logic [indexWidth-1:0]    f_idx, u_idx, n_idx;
    logic [WSEL-1:0]          f_word;
    logic [0:cacheLineWith-1] rd_line;
    logic                     hit_d;
    logic [1:0]               len_d;
    logic [0:BUNDLE-1]        bundle_d;
    int unsigned              rem;

    assign f_idx   = fetchAddress_i[tagWidth +: indexWidth];
    assign u_idx   = cacheUpdateAddress_i[tagWidth +: indexWidth];
    assign n_idx   = naturalWriteAddress_i[tagWidth +: indexWidth];
    assign f_word  = fetchAddress_i[tagWidth+indexWidth +: WSEL];
    assign rd_line = line_q[f_idx];
    assign hit_d   = valid_q[f_idx] && (tag_q[f_idx] == fetchAddress_i[0 +: tagWidth])
                     && (pid_q[f_idx] == Pid_i);

    logic unused_bits;
    assign unused_bits = ^{cacheUpdateAddress_i[addressWidth-offsetWidth +: offsetWidth],
                           naturalWriteAddress_i[addressWidth-offsetWidth +: offsetWidth],
                           tid_q[f_idx]};

    // Bundle is truncated at the end of the line; slots past the count stay zero.
    always_comb begin
        rem      = (WORDS - 1) - 32'(f_word);
        len_d    = (rem >= 3) ? 2'd3 : 2'(rem);
        bundle_d = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (k <= 32'(len_d)) begin
                bundle_d[k*instructionWidth +: instructionWidth] =
                    rd_line[(32'(f_word) + k)*instructionWidth +: instructionWidth];
            end
        end
    end

    // Refill is written after the natural write so it wins on a shared index.
    always_ff @(posedge clock_i) begin
        if (naturalWriteEn_i) begin
            tag_q[n_idx]  <= naturalWriteAddress_i[0 +: tagWidth];
            pid_q[n_idx]  <= naturalPid_i;
            tid_q[n_idx]  <= naturalTid_i;
            line_q[n_idx] <= naturalWriteLine_i;
        end
        if (cacheUpdate_i) begin
            tag_q[u_idx]  <= cacheUpdateAddress_i[0 +: tagWidth];
            pid_q[u_idx]  <= cacheUpdatePid_i;
            tid_q[u_idx]  <= cacheUpdateTid_i;
            line_q[u_idx] <= cacheUpdateLine_i;
        end
    end

    always_ff @(posedge clock_i or negedge cacheReset_i) begin
        if (!cacheReset_i) begin
            valid_q <= '0;
        end else begin
            if (naturalWriteEn_i) valid_q[n_idx] <= 1'b1;
            if (cacheUpdate_i)    valid_q[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge cacheReset_i) begin
        if (!cacheReset_i) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            oe_q     <= 1'b0;
            bundle_q <= '0;
            baddr_q  <= '0;
            blen_q   <= '0;
            bpid_q   <= '0;
            btid_q   <= '0;
            bstart_q <= '0;
            miss_q   <= 1'b0;
            maddr_q  <= '0;
            mid_q    <= '0;
            mpid_q   <= '0;
            mtid_q   <= '0;
        end else if (!fetchStall_i) begin
            case (state_q)
                RUN: begin
                    oe_q <= 1'b0;
                    if (fetchEnable_i) begin
                        if (hit_d) begin
                            oe_q     <= 1'b1;
                            bundle_q <= bundle_d;
                            baddr_q  <= fetchAddress_i;
                            blen_q   <= len_d;
                            bpid_q   <= Pid_i;
                            btid_q   <= Tid_i;
                            bstart_q <= cnt_q;
                            cnt_q    <= cnt_q + 64'(len_d) + 64'd1;
                        end else begin
                            miss_q  <= 1'b1;
                            maddr_q <= fetchAddress_i;
                            mid_q   <= cnt_q;
                            mpid_q  <= Pid_i;
                            mtid_q  <= Tid_i;
                            state_q <= MISS;
                        end
                    end
                end
                MISS: begin
                    oe_q <= 1'b0;
                    if (cacheUpdate_i) begin
                        cnt_q   <= missedInstMajorId_i;
                        miss_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign outputEnable_o      = oe_q;
    assign outputBundle_o      = bundle_q;
    assign bundleAddress_o     = baddr_q;
    assign bundleLen_o         = blen_q;
    assign bundlePid_o         = bpid_q;
    assign bundleTid_o         = btid_q;
    assign bundleStartMajId_o  = bstart_q;
    assign cacheMiss_o         = miss_q;
    assign missedAddress_o     = maddr_q;
    assign missedInstMajorId_o = mid_q;
    assign missedPid_o         = mpid_q;
    assign missedTid_o         = mtid_q;

endmodule

// File: tb/tb_l1i_cache.sv
// Directed bench for l1i_cache: hit streaming, truncation, miss/refill, stall,
// write priority, PID mismatch, reset during MISS and counter wrap.
module tb_l1i_cache;

    logic         clk;
    logic         rst_n;
    logic         fe, fs;
    logic [0:63]  faddr;
    logic [0:19]  pid;
    logic [0:15]  tid;
    logic         cu;
    logic [0:63]  cuaddr;
    logic [0:19]  cupid;
    logic [0:15]  cutid;
    logic [0:63]  cumid;
    logic [0:511] culine;
    logic         nwe;
    logic [0:63]  nwaddr;
    logic [0:511] nwline;
    logic [0:19]  npid;
    logic [0:15]  ntid;

    logic         oe;
    logic [0:127] bundle;
    logic [0:63]  baddr;
    logic [0:1]   blen;
    logic [0:19]  bpid;
    logic [0:15]  btid;
    logic [0:63]  bstart;
    logic         miss;
    logic [0:63]  maddr;
    logic [0:63]  mid;
    logic [0:19]  mpid;
    logic [0:15]  mtid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:511] pat, l1, l2;
    logic [31:0]  pw [6] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC,
                             32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};
    logic [127:0] exp4 [4] = '{128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD,
                               128'hEEEEEEEE_FFFFFFFF_AAAAAAAA_BBBBBBBB,
                               128'hCCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF,
                               128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD};

    l1i_cache dut (
        .clock_i(clk), .cacheReset_i(rst_n),
        .fetchEnable_i(fe), .fetchStall_i(fs), .fetchAddress_i(faddr),
        .Pid_i(pid), .Tid_i(tid),
        .cacheUpdate_i(cu), .cacheUpdateAddress_i(cuaddr), .cacheUpdatePid_i(cupid),
        .cacheUpdateTid_i(cutid), .missedInstMajorId_i(cumid), .cacheUpdateLine_i(culine),
        .naturalWriteEn_i(nwe), .naturalWriteAddress_i(nwaddr), .naturalWriteLine_i(nwline),
        .naturalPid_i(npid), .naturalTid_i(ntid),
        .outputEnable_o(oe), .outputBundle_o(bundle), .bundleAddress_o(baddr),
        .bundleLen_o(blen), .bundlePid_o(bpid), .bundleTid_o(btid),
        .bundleStartMajId_o(bstart), .cacheMiss_o(miss), .missedAddress_o(maddr),
        .missedInstMajorId_o(mid), .missedPid_o(mpid), .missedTid_o(mtid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; fe = 0; fs = 0; faddr = '0; pid = '0; tid = '0;
        cu = 0; cuaddr = '0; cupid = '0; cutid = '0; cumid = '0; culine = '0;
        nwe = 0; nwaddr = '0; nwline = '0; npid = '0; ntid = '0;
        for (int w = 0; w < 16; w++) pat[w*32 +: 32] = pw[w % 6];
        l1 = {16{32'h11111111}};
        l2 = {16{32'h22222222}};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_oe", 128'(oe), 128'd0);
        chk("rst_miss", 128'(miss), 128'd0);
        chk("rst_start", 128'(bstart), 128'd0);
        chk("rst_maddr", 128'(maddr), 128'd0);
        chk("rst_bundle", 128'(bundle), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int l = 0; l < 10; l++) begin
            nwe = 1; nwaddr = 64'(l) * 64'h40; nwline = pat;
            cyc();
        end
        nwe = 0;
        chk("idle_after_writes_oe", 128'(oe), 128'd0);

        fe = 1;
        for (int i = 0; i < 40; i++) begin
            faddr = 64'(i) * 64'h10;
            tid   = 16'(i);
            cyc();
            chk($sformatf("stream_oe[%0d]", i), 128'(oe), 128'd1);
            chk($sformatf("stream_miss[%0d]", i), 128'(miss), 128'd0);
            chk($sformatf("stream_len[%0d]", i), 128'(blen), 128'd3);
            chk($sformatf("stream_start[%0d]", i), 128'(bstart), 128'(4 * i));
            chk($sformatf("stream_addr[%0d]", i), 128'(baddr), 128'(16 * i));
            chk($sformatf("stream_tid[%0d]", i), 128'(btid), 128'(i));
            chk($sformatf("stream_bundle[%0d]", i), 128'(bundle), exp4[i % 4]);
        end

        fe = 0;
        cyc();
        chk("idle_oe", 128'(oe), 128'd0);
        chk("idle_bundle_hold", 128'(bundle), exp4[3]);
        chk("idle_addr_hold", 128'(baddr), 128'h270);
        chk("idle_start_hold", 128'(bstart), 128'h9C);

        fe = 1; faddr = 64'h38; tid = '0;
        cyc();
        chk("trunc2_oe", 128'(oe), 128'd1);
        chk("trunc2_len", 128'(blen), 128'd1);
        chk("trunc2_start", 128'(bstart), 128'hA0);
        chk("trunc2_bundle", 128'(bundle), 128'hCCCCCCCC_DDDDDDDD_00000000_00000000);

        faddr = 64'h3C;
        cyc();
        chk("trunc1_len", 128'(blen), 128'd0);
        chk("trunc1_start", 128'(bstart), 128'hA2);
        chk("trunc1_bundle", 128'(bundle), 128'hDDDDDDDD_00000000_00000000_00000000);

        faddr = 64'h280; tid = 16'h77;
        cyc();
        chk("miss_flag", 128'(miss), 128'd1);
        chk("miss_oe", 128'(oe), 128'd0);
        chk("miss_addr", 128'(maddr), 128'h280);
        chk("miss_id", 128'(mid), 128'hA3);
        chk("miss_tid", 128'(mtid), 128'h77);

        faddr = 64'h000; tid = '0;
        cyc();
        chk("inmiss_oe", 128'(oe), 128'd0);
        chk("inmiss_flag", 128'(miss), 128'd1);
        chk("inmiss_addr_hold", 128'(maddr), 128'h280);

        fe = 0; cu = 1; cuaddr = 64'h280; cumid = 64'hA0; culine = pat; cupid = '0; cutid = 16'h5;
        cyc();
        cu = 0;
        chk("refill_miss_clr", 128'(miss), 128'd0);
        chk("refill_oe", 128'(oe), 128'd0);

        fe = 1; faddr = 64'h280;
        cyc();
        chk("refetch_oe", 128'(oe), 128'd1);
        chk("refetch_start", 128'(bstart), 128'hA0);
        chk("refetch_bundle", 128'(bundle), exp4[0]);
        chk("refetch_addr", 128'(baddr), 128'h280);

        fs = 1; faddr = 64'h010;
        cyc();
        chk("stall_oe_hold", 128'(oe), 128'd1);
        chk("stall_start_hold", 128'(bstart), 128'hA0);
        chk("stall_bundle_hold", 128'(bundle), exp4[0]);

        fs = 0;
        cyc();
        chk("unstall_start", 128'(bstart), 128'hA4);
        chk("unstall_bundle", 128'(bundle), exp4[1]);

        pid = 20'h1; faddr = 64'h000;
        cyc();
        chk("pid_miss_flag", 128'(miss), 128'd1);
        chk("pid_miss_oe", 128'(oe), 128'd0);
        chk("pid_miss_pid", 128'(mpid), 128'h1);
        chk("pid_miss_id", 128'(mid), 128'hA8);

        fe = 0; pid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("midmiss_rst_miss", 128'(miss), 128'd0);
        chk("midmiss_rst_oe", 128'(oe), 128'd0);
        chk("midmiss_rst_start", 128'(bstart), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        fe = 1; faddr = 64'h000;
        cyc();
        chk("postrst_miss", 128'(miss), 128'd1);
        chk("postrst_id", 128'(mid), 128'd0);
        chk("postrst_oe", 128'(oe), 128'd0);

        fe = 0; cu = 1; cuaddr = 64'h000; culine = l1; cumid = 64'h10;
        nwe = 1; nwaddr = 64'h000; nwline = l2;
        cyc();
        chk("prio_miss_clr", 128'(miss), 128'd0);

        fe = 1; faddr = 64'h000; cuaddr = 64'h040; culine = l1; cumid = '0;
        cyc();
        cu = 0; nwe = 0;
        chk("prio_bundle_l1", 128'(bundle), {4{32'h11111111}});
        chk("prio_start", 128'(bstart), 128'h10);
        chk("run_update_nomiss", 128'(miss), 128'd0);

        faddr = 64'h000;
        cyc();
        chk("newdata_bundle_l2", 128'(bundle), {4{32'h22222222}});
        chk("newdata_start", 128'(bstart), 128'h14);

        faddr = 64'h040;
        cyc();
        chk("dual_write_bundle", 128'(bundle), {4{32'h11111111}});
        chk("dual_write_start", 128'(bstart), 128'h18);

        faddr = 64'h300;
        cyc();
        chk("wrapmiss_flag", 128'(miss), 128'd1);
        chk("wrapmiss_id", 128'(mid), 128'h1C);

        fe = 0; cu = 1; cuaddr = 64'h300; culine = pat; cumid = 64'hFFFF_FFFF_FFFF_FFFE;
        cyc();
        cu = 0;

        fe = 1; faddr = 64'h300;
        cyc();
        chk("wrap_start_hi", 128'(bstart), 128'hFFFF_FFFF_FFFF_FFFE);

        faddr = 64'h310;
        cyc();
        chk("wrap_start_lo", 128'(bstart), 128'h2);
        chk("wrap_bundle", 128'(bundle), exp4[1]);

        fe = 0;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
